// File: rtl/ddr_cmd_scheduler.sv
// DDR command scheduler: arbitrates button write/read requests and periodic refresh
// into one-hot command levels. Define DDR_SCHED_DEBOUNCE_EN to enable button debouncing.
module ddr_cmd_scheduler #(
  parameter int REFI_CYCLES  = 6400000,
  parameter int DEB_CYCLES   = 1000000,
  parameter int MAX_POSTPONE = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       btn_write,
  input  logic       btn_read,
  input  logic       ctrl_idle,
  output logic       WRITE,
  output logic       READ,
  output logic       REF,
  output logic [3:0] pend_ref,
  output logic       ref_overflow
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_BUSY} state_e;
  typedef enum logic [1:0] {C_WR, C_RD, C_REF} cmd_e;

  localparam int RW = (REFI_CYCLES > 2) ? $clog2(REFI_CYCLES) : 1;
  localparam logic [RW-1:0] REFI_LAST = RW'(REFI_CYCLES - 1);
  localparam logic [3:0] MAXP = 4'(MAX_POSTPONE);

  if (MAX_POSTPONE < 1 || MAX_POSTPONE > 15 || DEB_CYCLES < 1 || REFI_CYCLES < 2) begin : g_bad_param
    $error("ddr_cmd_scheduler: parameter out of range");
  end

  // Bit 0 is the write button, bit 1 the read button throughout the front end.
  logic [1:0] btn_raw, sync1_q, sync2_q, lvl, lvl_prev_q, rise;
  assign btn_raw = {btn_read, btn_write};

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      lvl_prev_q <= '0;
    end else begin
      sync1_q    <= btn_raw;
      sync2_q    <= sync1_q;
      lvl_prev_q <= lvl;
    end
  end

`ifdef DDR_SCHED_DEBOUNCE_EN
  localparam int DW = $clog2(DEB_CYCLES + 1);
  logic [DW-1:0] deb_cnt_q [2];
  logic [1:0]    deb_lvl_q;

  // NOTE: the counter array is only two registers, so it is reset like any other flop.
  always_ff @(posedge CLK) begin
    if (RST) begin
      deb_lvl_q <= '0;
      for (int i = 0; i < 2; i++) deb_cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] == deb_lvl_q[i]) begin
          deb_cnt_q[i] <= '0;
        end else if (deb_cnt_q[i] == DW'(DEB_CYCLES - 1)) begin
          deb_lvl_q[i] <= sync2_q[i];
          deb_cnt_q[i] <= '0;
        end else begin
          deb_cnt_q[i] <= deb_cnt_q[i] + DW'(1);
        end
      end
    end
  end
  assign lvl = deb_lvl_q;
`else
  assign lvl = sync2_q;
`endif

  assign rise = lvl & ~lvl_prev_q;

  state_e        state_q;
  cmd_e          sel_q, sel_d;
  logic [RW-1:0] refi_cnt_q;
  logic          wr_pend_q, rd_pend_q;
  logic          write_q, read_q, ref_q;
  logic [3:0]    pend_ref_q, pend_ref_d;
  logic          ref_overflow_q, ref_overflow_d;
  logic          tick, cmd_on, any_req, leave, ref_take;

  assign tick     = (refi_cnt_q == REFI_LAST);
  assign cmd_on   = write_q | read_q | ref_q;
  assign any_req  = wr_pend_q | rd_pend_q | (pend_ref_q != 4'd0);
  assign leave    = (state_q == S_ISSUE) && cmd_on && !ctrl_idle;
  assign ref_take = leave && (sel_q == C_REF);

  // NOTE: every path below assigns sel_d, so no latch is inferred.
  always_comb begin
    if (pend_ref_q == MAXP) sel_d = C_REF;
    else if (wr_pend_q)     sel_d = C_WR;
    else if (rd_pend_q)     sel_d = C_RD;
    else                    sel_d = C_REF;
  end

  // A tick and a refresh consumption in the same cycle cancel out.
  always_comb begin
    pend_ref_d     = pend_ref_q;
    ref_overflow_d = ref_overflow_q;
    if (tick && !ref_take) begin
      if (pend_ref_q == MAXP) ref_overflow_d = 1'b1;
      else                    pend_ref_d     = pend_ref_q + 4'd1;
    end else if (ref_take && !tick) begin
      pend_ref_d = pend_ref_q - 4'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q        <= S_IDLE;
      sel_q          <= C_WR;
      refi_cnt_q     <= '0;
      wr_pend_q      <= 1'b0;
      rd_pend_q      <= 1'b0;
      write_q        <= 1'b0;
      read_q         <= 1'b0;
      ref_q          <= 1'b0;
      pend_ref_q     <= '0;
      ref_overflow_q <= 1'b0;
    end else begin
      refi_cnt_q     <= tick ? '0 : refi_cnt_q + RW'(1);
      pend_ref_q     <= pend_ref_d;
      ref_overflow_q <= ref_overflow_d;

      if (leave && sel_q == C_WR) wr_pend_q <= 1'b0;
      else if (rise[0])           wr_pend_q <= 1'b1;
      if (leave && sel_q == C_RD) rd_pend_q <= 1'b0;
      else if (rise[1])           rd_pend_q <= 1'b1;

      // The selection is latched in IDLE; ISSUE raises it one cycle later.
      case (state_q)
        S_IDLE: begin
          if (ctrl_idle && any_req) begin
            sel_q   <= sel_d;
            state_q <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (!cmd_on) begin
            write_q <= (sel_q == C_WR);
            read_q  <= (sel_q == C_RD);
            ref_q   <= (sel_q == C_REF);
          end else if (!ctrl_idle) begin
            write_q <= 1'b0;
            read_q  <= 1'b0;
            ref_q   <= 1'b0;
            state_q <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (ctrl_idle) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign WRITE        = write_q;
  assign READ         = read_q;
  assign REF          = ref_q;
  assign pend_ref     = pend_ref_q;
  assign ref_overflow = ref_overflow_q;

endmodule
